// File: rtl/barret_mul_feed_pkg.sv
// Shared NTT constants and FSM state type for the Barrett product feeder.
package barret_mul_feed_pkg;

    localparam logic [31:0] Q = 32'd8380417;
    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/radix4_digit_add.sv
// One radix-4 partial-product step: sum = acc + ((digit * a) << shift).
module radix4_digit_add #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ShiftW = 5
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [1:0]         digit,
    input  logic [ShiftW-1:0]  shift,
    output logic [2*WIDTH-1:0] sum
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] partial;

    always_comb begin
        a_ext   = {{WIDTH{1'b0}}, a};
        partial = '0;
        case (digit)
            2'd0: partial = '0;
            2'd1: partial = a_ext;
            2'd2: partial = a_ext << 1;
            2'd3: partial = a_ext + (a_ext << 1);
            default: partial = '0;
        endcase
        // Final product fits in 2*WIDTH bits, so the carry-out is dropped.
        sum = acc + (partial << shift);
    end

endmodule

// File: rtl/barret_mul_feed.sv
// Sequential radix-4 multiplier feeding the Barrett reducer with a 2*WIDTH-bit product.
// Optional operand range flag enabled by defining BARRET_FEED_RANGE_CHECK_EN.
module barret_mul_feed
    import barret_mul_feed_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               range_err
);

    localparam int unsigned Iters  = WIDTH / 2;
    localparam int unsigned CntW   = (Iters > 1) ? $clog2(Iters) : 1;
    localparam int unsigned ShiftW = CntW + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] c_q, c_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [ShiftW-1:0]  shift;
    logic [1:0]         digit;
    logic [2*WIDTH-1:0] sum;
    logic               accept;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign shift     = {cnt_q, 1'b0};
    assign digit     = b_q[shift +: 2];
    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign busy      = busy_q;

    radix4_digit_add #(
        .WIDTH (WIDTH),
        .ShiftW(ShiftW)
    ) u_digit_add (
        .acc  (acc_q),
        .a    (a_q),
        .digit(digit),
        .shift(shift),
        .sum  (sum)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    c_d         = sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef BARRET_FEED_RANGE_CHECK_EN
    localparam int unsigned ExtW = (WIDTH > 32) ? WIDTH : 32;

    logic range_q, range_d;

    // Flag is captured at accept and held for the whole life of that operand pair.
    always_comb begin
        range_d = range_q;
        if (accept) begin
            range_d = (ExtW'(a) >= ExtW'(Q)) || (ExtW'(b) >= ExtW'(Q));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_q <= 1'b0;
        end else begin
            range_q <= range_d;
        end
    end

    assign range_err = range_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_barret_mul_feed.sv
// Self-checking bench for barret_mul_feed: directed corner cases plus random operands.
module tb_barret_mul_feed;
    import barret_mul_feed_pkg::*;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] C;
    logic           busy;
    logic           range_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    barret_mul_feed #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .C        (C),
        .busy     (busy),
        .range_err(range_err)
    );

    function automatic logic ref_range(input logic [31:0] x, input logic [31:0] y);
`ifdef BARRET_FEED_RANGE_CHECK_EN
        return (x >= Q) || (y >= Q);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full transaction: present x*y, wait for the product, stall `stall` cycles, then take it.
    // With hold set, in_valid stays high carrying (nx, ny) from the cycle after accept.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int stall,
                          input bit hold, input logic [31:0] nx, input logic [31:0] ny);
        logic [63:0] exp_c;
        logic        exp_r;
        bit          seen;
        int          lat;
        exp_c = 64'(x) * 64'(y);
        exp_r = ref_range(x, y);
        a = x;
        b = y;
        in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (in_ready) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("ready_before_accept", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            a = nx;
            b = ny;
        end else begin
            in_valid = 1'b0;
        end
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        check("range_err_at_accept", 64'(range_err), 64'(exp_r));
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (out_valid) seen = 1'b1;
        end
        check("latency", 64'(lat), 64'(W / 2));
        check("product", C, exp_c);
        check("range_err_done", 64'(range_err), 64'(exp_r));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_C", C, exp_c);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_busy", 64'(busy), 64'd0);
        check("post_hs_C_kept", C, exp_c);
    endtask

    initial begin
        logic [31:0] rx, ry;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_C", C, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 0, 1'b0, '0, '0);
        run_op(32'd8380416, 32'd8380416, 0, 1'b0, '0, '0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, 32'd0, 32'd7);
        run_op(32'd0, 32'd7, 0, 1'b0, '0, '0);
        run_op(32'd12345, 32'd0, 1, 1'b0, '0, '0);
        run_op(32'd8380417, 32'd1, 0, 1'b0, '0, '0);
        run_op(32'd1, 32'd1, 0, 1'b0, '0, '0);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                rx = $urandom_range(0, 32'd8380418);
                ry = $urandom_range(0, 32'd8380418);
            end else begin
                rx = $urandom;
                ry = $urandom;
            end
            run_op(rx, ry, int'($urandom_range(0, 3)), 1'b0, '0, '0);
        end

        // Abort a multiplication partway through with an asynchronous reset.
        a = 32'd123456;
        b = 32'd654321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_C", C, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_range_err", 64'(range_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd7, 32'd9, 0, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
